aes_mode_ctrl: RTL

//  Multi-block AES-128 mode controller: streams a message of msg_len 128-bit blocks through one external

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_mode_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES mode controller.
//  AES_BLK_W          : cipher block / key / IV width (AES-128 only)
//  MODE_* / DIR_*     : cfg_mode and cfg_dir encodings
//  state_t            : controller FSM states
package aes_pkg;

  localparam int AES_BLK_W = 128;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;

  localparam logic DIR_ENC  = 1'b0;
  localparam logic DIR_DEC  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/aes_mode_ctrl.sv
// Multi-block AES-128 mode controller.
// Streams msg_len blocks one at a time through an external single-block
// cipher engine in ECB or CBC mode, encrypt or decrypt, and owns the IV
// chaining, block counting, stream handshakes and the engine timeout.
// Ports:
//  clk, rest                  clock, async active-high reset
//  cfg_mode/dir/key/iv,msg_len message configuration, latched at accepted msg_start
//  msg_start                  start pulse, accepted in IDLE only
//  in_valid/in_ready/in_data  input block stream (in_ready only in LOAD)
//  out_valid/out_ready/out_data/out_last  output block stream
//  busy, done, error          status (done one-cycle pulse, error sticky)
//  core_start/dir/din/key     request to the cipher engine
//  core_dout/core_done        engine result
module aes_mode_ctrl
  import aes_pkg::*;
#(
  parameter int BLK_W   = AES_BLK_W,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             cfg_mode,
  input  logic             cfg_dir,
  input  logic [BLK_W-1:0] cfg_key,
  input  logic [BLK_W-1:0] cfg_iv,
  input  logic [CNT_W-1:0] msg_len,
  input  logic             msg_start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             core_start,
  output logic             core_dir,
  output logic [BLK_W-1:0] core_din,
  output logic [BLK_W-1:0] core_key,
  input  logic [BLK_W-1:0] core_dout,
  input  logic             core_done
);

  localparam int               TMR_W   = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state;
  logic               mode_q;
  logic               dir_q;
  logic [BLK_W-1:0]   key_q;
  logic [BLK_W-1:0]   chain_q;
  logic [BLK_W-1:0]   din_q;
  logic [BLK_W-1:0]   out_data_q;
  logic               out_last_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TMR_W-1:0]   tmr_q;
  logic               error_q;
  logic               start_q;

  logic               cbc_enc;
  logic               cbc_dec;

  assign cbc_enc = (mode_q == MODE_CBC) && (dir_q == DIR_ENC);
  assign cbc_dec = (mode_q == MODE_CBC) && (dir_q == DIR_DEC);

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state      <= ST_IDLE;
      mode_q     <= 1'b0;
      dir_q      <= 1'b0;
      key_q      <= '0;
      chain_q    <= '0;
      din_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      error_q    <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      // core_start is a single-cycle pulse in the first RUN cycle
      start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (msg_start) begin
            mode_q  <= cfg_mode;
            dir_q   <= cfg_dir;
            key_q   <= cfg_key;
            chain_q <= cfg_iv;
            len_q   <= msg_len;
            cnt_q   <= '0;
            error_q <= 1'b0;
            state   <= (msg_len == '0) ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            // CBC encrypt whitens the plaintext before the cipher; every
            // other mode feeds the block straight through. din_q also
            // serves as the next chain value for CBC decrypt.
            din_q   <= cbc_enc ? (in_data ^ chain_q) : in_data;
            tmr_q   <= '0;
            start_q <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A done coincident with our own start pulse is stale and ignored.
          // A done arriving exactly at the timeout limit still wins.
          if (core_done && !start_q) begin
            out_data_q <= cbc_dec ? (core_dout ^ chain_q) : core_dout;
            out_last_q <= (cnt_q == len_q - CNT_ONE);
            if (mode_q == MODE_CBC)
              chain_q <= (dir_q == DIR_DEC) ? din_q : core_dout;
            state <= ST_OUT;
          end else if (tmr_q == TMR_MAX) begin
            error_q <= 1'b1;
            state   <= ST_ERR;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            cnt_q <= cnt_q + CNT_ONE;
            state <= out_last_q ? ST_DONE : ST_LOAD;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state == ST_LOAD) || (state == ST_RUN) ||
                      (state == ST_OUT)  || (state == ST_DONE);
  assign in_ready   = (state == ST_LOAD);
  assign out_valid  = (state == ST_OUT);
  assign done       = (state == ST_DONE);
  assign error      = error_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign core_start = start_q;
  assign core_dir   = dir_q;
  assign core_din   = din_q;
  assign core_key   = key_q;

endmodule
